// File: rtl/gpio_ctrl.sv
// gpio_ctrl: Wishbone GPIO register block with per-pin edge interrupts.
// Ports: clk_i/rst_ni (sync low), wb_* slave, gpio_dat_o/gpio_dir_o/gpio_in_i bank, irq_o.
module gpio_ctrl #(
   parameter int NUM_PINS = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic                wb_we_i,
   input  logic [4:0]          wb_adr_i,
   input  logic [3:0]          wb_sel_i,
   input  logic [31:0]         wb_dat_i,
   output logic [31:0]         wb_dat_o,
   output logic                wb_ack_o,
   output logic [NUM_PINS-1:0] gpio_dat_o,
   output logic [NUM_PINS-1:0] gpio_dir_o,
   input  logic [NUM_PINS-1:0] gpio_in_i,
   output logic                irq_o
);

   localparam int W = NUM_PINS;

   typedef enum logic [2:0] {
      A_DAT  = 3'd0,
      A_DIR  = 3'd1,
      A_IN   = 3'd2,
      A_IE   = 3'd3,
      A_EDGE = 3'd4,
      A_IP   = 3'd5,
      A_RS6  = 3'd6,
      A_RS7  = 3'd7
   } addr_e;

   // register file
   logic [W-1:0] r_dat;
   logic [W-1:0] r_dir;
   logic [W-1:0] r_ie;
   logic [W-1:0] r_edge;
   logic [W-1:0] r_ip;

   // input synchronizer and edge history
   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;
   logic [W-1:0] r_s3;
   logic [1:0]   r_arm;

   // bus response
   logic         r_ack;
   logic [31:0]  r_rdata;

   // decode
   addr_e        w_addr;
   logic         w_req;
   logic         w_wr;
   logic [31:0]  w_bmask;
   logic [W-1:0] w_wmask;
   logic [W-1:0] w_wdata;
   logic [31:0]  w_rdata;

   // event path
   logic         w_armed;
   logic [W-1:0] w_rise;
   logic [W-1:0] w_fall;
   logic [W-1:0] w_evt;
   logic [W-1:0] w_ip_clr;
   logic [W-1:0] w_ip_nxt;

   logic         w_unused;

   function automatic logic [W-1:0] merge(
      input logic [W-1:0] old,
      input logic [W-1:0] d,
      input logic [W-1:0] m
   );
      return (old & ~m) | (d & m);
   endfunction

   assign w_addr  = addr_e'(wb_adr_i[4:2]);
   // ack in flight blocks a new request: one ack per two cycles
   assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_wr    = w_req & wb_we_i;

   assign w_bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                     {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign w_wmask = w_bmask[W-1:0];
   assign w_wdata = wb_dat_i[W-1:0];

   // bits outside the pin range and the byte offset are not decoded
   assign w_unused = ^{wb_adr_i[1:0], wb_dat_i, w_bmask};

   // ---------------- edge detection ----------------

   assign w_armed = (r_arm == 2'd3);
   assign w_rise  = r_s2 & ~r_s3;
   assign w_fall  = ~r_s2 & r_s3;
   assign w_evt   = w_armed ?
                    ((r_edge & w_rise) | (~r_edge & w_fall)) :
                    '0;

   assign w_ip_clr = (w_wr && w_addr == A_IP) ?
                     (w_wdata & w_wmask) : '0;

   // new events are OR-ed after the clear so a coincident set wins
   assign w_ip_nxt = (r_ip & ~w_ip_clr) | w_evt;

   // ---------------- read mux ----------------

   always_comb begin
      w_rdata = '0;
      case (w_addr)
         A_DAT:   w_rdata[W-1:0] = r_dat;
         A_DIR:   w_rdata[W-1:0] = r_dir;
         A_IN:    w_rdata[W-1:0] = r_s2;
         A_IE:    w_rdata[W-1:0] = r_ie;
         A_EDGE:  w_rdata[W-1:0] = r_edge;
         A_IP:    w_rdata[W-1:0] = r_ip;
         default: w_rdata = '0;
      endcase
   end

   // ---------------- bus response ----------------

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= w_req;
         if (w_req) begin
            r_rdata <= w_rdata;
         end
      end
   end

   // ---------------- writable registers ----------------

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_dat  <= '0;
         r_dir  <= '0;
         r_ie   <= '0;
         r_edge <= '0;
      end else if (w_wr) begin
         case (w_addr)
            A_DAT:  r_dat  <= merge(r_dat, w_wdata, w_wmask);
            A_DIR:  r_dir  <= merge(r_dir, w_wdata, w_wmask);
            A_IE:   r_ie   <= merge(r_ie, w_wdata, w_wmask);
            A_EDGE: r_edge <= merge(r_edge, w_wdata, w_wmask);
            default: ;
         endcase
      end
   end

   // ---------------- input path and pending flags ----------------

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_s1  <= '0;
         r_s2  <= '0;
         r_s3  <= '0;
         r_arm <= 2'd0;
         r_ip  <= '0;
      end else begin
         r_s1 <= gpio_in_i;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         // hold off events until the sync chain has filled
         if (!w_armed) begin
            r_arm <= r_arm + 2'd1;
         end
         r_ip <= w_ip_nxt;
      end
   end

   assign wb_ack_o   = r_ack;
   assign wb_dat_o   = r_rdata;
   assign gpio_dat_o = r_dat;
   assign gpio_dir_o = r_dir;
   assign irq_o      = |(r_ip & r_ie);

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed table and sequence bench for gpio_ctrl.
// Drives the Wishbone port and pin inputs, checks outputs and readbacks.
module tb_gpio_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [4:0]  adr;
   logic [3:0]  sel;
   logic [31:0] wdat;
   logic [31:0] rdat;
   logic        ack;
   logic [7:0]  gdat, gdir, gin;
   logic        irq;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gpio_ctrl #(.NUM_PINS(8)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_we_i    (we),
      .wb_adr_i   (adr),
      .wb_sel_i   (sel),
      .wb_dat_i   (wdat),
      .wb_dat_o   (rdat),
      .wb_ack_o   (ack),
      .gpio_dat_o (gdat),
      .gpio_dir_o (gdir),
      .gpio_in_i  (gin),
      .irq_o      (irq)
   );

   typedef struct {
      logic [2:0]  idx;
      logic [31:0] wd;
      logic [3:0]  sel;
      logic [31:0] exp_rd;
      logic [7:0]  exp_dat;
      logic [7:0]  exp_dir;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // advance n rising edges, then step just past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic [2:0] idx,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd);
      int n;
      cyc = 1'b1; stb = 1'b1; we = w;
      adr = {idx, 2'b00}; wdat = d; sel = s;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!ack && n < 4);
      chk("bus_ack", {31'd0, ack}, 32'd1);
      rd = rdat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] d,
                     input logic [3:0] s);
      logic [31:0] rd;
      bus(1'b1, idx, d, s, rd);
   endtask

   task automatic rd_chk(input string nm, input logic [2:0] idx,
                         input logic [31:0] exp);
      logic [31:0] rd;
      bus(1'b0, idx, 32'd0, 4'h0, rd);
      chk(nm, rd, exp);
   endtask

   task automatic drive(input logic w, input logic [2:0] idx,
                        input logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = w;
      adr = {idx, 2'b00}; wdat = d; sel = 4'hF;
   endtask

   task automatic idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   initial begin
      logic [31:0] burst;
      vecs[0]  = '{3'd0, 32'h0000_00A5, 4'b0001, 32'h0000_00A5, 8'hA5, 8'h00};
      vecs[1]  = '{3'd1, 32'h0000_000F, 4'b0001, 32'h0000_000F, 8'hA5, 8'h0F};
      vecs[2]  = '{3'd0, 32'h1234_5678, 4'b0010, 32'h0000_00A5, 8'hA5, 8'h0F};
      vecs[3]  = '{3'd0, 32'hFFFF_FF3C, 4'b1111, 32'h0000_003C, 8'h3C, 8'h0F};
      vecs[4]  = '{3'd1, 32'h0000_AA00, 4'b0010, 32'h0000_000F, 8'h3C, 8'h0F};
      vecs[5]  = '{3'd2, 32'h0000_0000, 4'b1111, 32'h0000_00FF, 8'h3C, 8'h0F};
      vecs[6]  = '{3'd3, 32'hFFFF_FF00, 4'b1111, 32'h0000_0000, 8'h3C, 8'h0F};
      vecs[7]  = '{3'd4, 32'hFFFF_FFFF, 4'b0001, 32'h0000_00FF, 8'h3C, 8'h0F};
      vecs[8]  = '{3'd6, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 8'h3C, 8'h0F};
      vecs[9]  = '{3'd7, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 8'h3C, 8'h0F};
      vecs[10] = '{3'd4, 32'h0000_0001, 4'b0001, 32'h0000_0001, 8'h3C, 8'h0F};
      vecs[11] = '{3'd0, 32'h0000_00A5, 4'b0001, 32'h0000_00A5, 8'hA5, 8'h0F};

      rst_n = 1'b0;
      idle();
      adr = '0; sel = '0; wdat = '0;
      gin = 8'hFF;

      // reset state
      tick(2);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_rdat", rdat, 32'd0);
      chk("rst_dat", {24'd0, gdat}, 32'd0);
      chk("rst_dir", {24'd0, gdir}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("arm_irq", {31'd0, irq}, 32'd0);
         chk("arm_dir", {24'd0, gdir}, 32'd0);
      end
      rd_chk("arm_ip", 3'd5, 32'd0);
      rd_chk("arm_in", 3'd2, 32'h0000_00FF);

      // register table
      for (int i = 0; i < 12; i++) begin
         wr(vecs[i].idx, vecs[i].wd, vecs[i].sel);
         chk("tbl_dat", {24'd0, gdat}, {24'd0, vecs[i].exp_dat});
         chk("tbl_dir", {24'd0, gdir}, {24'd0, vecs[i].exp_dir});
         tick(1);
         chk("tbl_ack_1cyc", {31'd0, ack}, 32'd0);
         rd_chk("tbl_rd", vecs[i].idx, vecs[i].exp_rd);
      end

      // output changes on the ack edge, not in the request cycle
      tick(1);
      drive(1'b1, 3'd0, 32'h0000_0066);
      chk("dat_req_cycle", {24'd0, gdat}, 32'h0000_00A5);
      tick(1);
      chk("dat_ack", {31'd0, ack}, 32'd1);
      chk("dat_after", {24'd0, gdat}, 32'h0000_0066);
      idle();
      tick(1);

      // interrupts: EDGE=01, IE=00, pins FF
      gin = 8'h00;
      tick(5);
      rd_chk("fall_ip", 3'd5, 32'h0000_00FE);
      wr(3'd5, 32'h0000_00FF, 4'b0001);
      rd_chk("w1c_all", 3'd5, 32'd0);
      wr(3'd3, 32'h0000_0001, 4'b0001);
      gin = 8'h01;
      tick(2);
      chk("irq_pre_e3", {31'd0, irq}, 32'd0);
      tick(1);
      chk("irq_at_e3", {31'd0, irq}, 32'd1);
      rd_chk("rise_ip", 3'd5, 32'h0000_0001);

      gin = 8'h03;
      tick(5);
      gin = 8'h01;
      tick(5);
      rd_chk("pin1_fall_ip", 3'd5, 32'h0000_0003);
      chk("irq_two_ip", {31'd0, irq}, 32'd1);
      wr(3'd3, 32'h0000_0000, 4'b0001);
      chk("ie_masks", {31'd0, irq}, 32'd0);
      wr(3'd3, 32'h0000_0001, 4'b0001);
      chk("ie_unmask", {31'd0, irq}, 32'd1);
      wr(3'd5, 32'h0000_0001, 4'b0001);
      tick(1);
      chk("irq_bit0_only", {31'd0, irq}, 32'd0);
      rd_chk("ip_bit1_left", 3'd5, 32'h0000_0002);
      wr(3'd5, 32'h0000_0002, 4'b0001);

      // set beats a coincident W1C
      gin = 8'h00;
      tick(5);
      gin = 8'h01;
      tick(5);
      chk("sw_irq_pre", {31'd0, irq}, 32'd1);
      gin = 8'h00;
      tick(5);
      rd_chk("sw_fall_quiet", 3'd5, 32'h0000_0001);
      gin = 8'h01;
      tick(2);
      drive(1'b1, 3'd5, 32'h0000_0001);
      tick(1);
      chk("sw_ack", {31'd0, ack}, 32'd1);
      chk("sw_irq", {31'd0, irq}, 32'd1);
      idle();
      tick(1);
      rd_chk("sw_ip", 3'd5, 32'h0000_0001);
      chk("sw_irq_hold", {31'd0, irq}, 32'd1);
      wr(3'd5, 32'h0000_0001, 4'b0001);
      tick(1);
      chk("clr_irq", {31'd0, irq}, 32'd0);
      rd_chk("clr_ip", 3'd5, 32'd0);

      // continuous strobe: ack every other cycle
      tick(1);
      drive(1'b0, 3'd0, 32'd0);
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         chk("burst_ack", {31'd0, ack}, {31'd0, k[0]});
         burst = rdat;
         if (ack) chk("burst_dat", burst, 32'h0000_0066);
      end
      idle();
      tick(1);

      // reset in the middle of a strobe burst
      drive(1'b0, 3'd1, 32'd0);
      tick(1);
      chk("mid_ack1", {31'd0, ack}, 32'd1);
      tick(1);
      chk("mid_ack2", {31'd0, ack}, 32'd0);
      rst_n = 1'b0;
      tick(1);
      chk("mid_rst_ack", {31'd0, ack}, 32'd0);
      chk("mid_rst_rdat", rdat, 32'd0);
      chk("mid_rst_dat", {24'd0, gdat}, 32'd0);
      chk("mid_rst_dir", {24'd0, gdir}, 32'd0);
      rst_n = 1'b1;
      idle();
      tick(1);
      chk("mid_rst_irq", {31'd0, irq}, 32'd0);
      rd_chk("post_dat", 3'd0, 32'd0);
      rd_chk("post_dir", 3'd1, 32'd0);
      rd_chk("post_ie", 3'd3, 32'd0);
      rd_chk("post_edge", 3'd4, 32'd0);
      rd_chk("post_ip", 3'd5, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
